// File: rtl/hour_set_ctrl.sv
// Interactive hour editor: preloads BCD digits (12h or 24h view) from the
// committed hour, edits them with one-pulse buttons and commits a binary 0-23 hour.
module hour_set_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_12,
    input  logic       start,
    input  logic       inc,
    input  logic       next,
    input  logic       abort,
    output logic [4:0] hour_value,
    output logic       load,
    output logic [3:0] hr1_edit,
    output logic [3:0] hr0_edit,
    output logic       pm_edit,
    output logic       editing,
    output logic [1:0] field
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TENS = 2'd1,
        ONES = 2'd2,
        AMPM = 2'd3
    } state_t;

    state_t     state_reg;
    logic       mode_12_reg;
    logic [4:0] hour_value_reg;
    logic       load_reg;
    logic [3:0] hr1_reg;
    logic [3:0] hr0_reg;
    logic       pm_reg;
    logic       editing_reg;

    // Preload: convert the committed hour into the display form of the requested mode
    logic [4:0] disp_hour;
    logic       disp_pm;
    logic [4:0] disp_ones_full;
    logic [3:0] pre_tens;
    logic [3:0] pre_ones;

    always_comb begin
        disp_hour = hour_value_reg;
        disp_pm   = 1'b0;
        if (mode_12) begin
            if (hour_value_reg == 5'd0) begin
                disp_hour = 5'd12;
            end else if (hour_value_reg == 5'd12) begin
                disp_pm = 1'b1;
            end else if (hour_value_reg > 5'd12) begin
                disp_hour = hour_value_reg - 5'd12;
                disp_pm   = 1'b1;
            end
        end
        if (disp_hour >= 5'd20) begin
            pre_tens       = 4'd2;
            disp_ones_full = disp_hour - 5'd20;
        end else if (disp_hour >= 5'd10) begin
            pre_tens       = 4'd1;
            disp_ones_full = disp_hour - 5'd10;
        end else begin
            pre_tens       = 4'd0;
            disp_ones_full = disp_hour;
        end
        pre_ones = disp_ones_full[3:0];
    end

    // Field increments, including the ones clamp that keeps the hour legal
    logic [3:0] tens_inc;
    logic [3:0] ones_clamped;
    logic [3:0] ones_inc;

    always_comb begin
        tens_inc     = 4'd0;
        ones_clamped = hr0_reg;
        ones_inc     = hr0_reg + 4'd1;
        if (mode_12_reg) begin
            tens_inc = (hr1_reg == 4'd0) ? 4'd1 : 4'd0;
            if (tens_inc == 4'd1 && hr0_reg > 4'd2)
                ones_clamped = 4'd2;
            else if (tens_inc == 4'd0 && hr0_reg == 4'd0)
                ones_clamped = 4'd1;
            if (hr1_reg == 4'd0)
                ones_inc = (hr0_reg >= 4'd9) ? 4'd1 : hr0_reg + 4'd1;
            else
                ones_inc = (hr0_reg >= 4'd2) ? 4'd0 : hr0_reg + 4'd1;
        end else begin
            tens_inc = (hr1_reg >= 4'd2) ? 4'd0 : hr1_reg + 4'd1;
            if (tens_inc == 4'd2 && hr0_reg > 4'd3)
                ones_clamped = 4'd3;
            if (hr1_reg < 4'd2)
                ones_inc = (hr0_reg >= 4'd9) ? 4'd0 : hr0_reg + 4'd1;
            else
                ones_inc = (hr0_reg >= 4'd3) ? 4'd0 : hr0_reg + 4'd1;
        end
    end

    // Commit: digits back to binary 24-hour
    logic [4:0] tens_w;
    logic [4:0] h_bin;
    logic [4:0] commit_value;

    always_comb begin
        tens_w = {1'b0, hr1_reg};
        h_bin  = (tens_w << 3) + (tens_w << 1) + {1'b0, hr0_reg};
        commit_value = h_bin;
        if (mode_12_reg) begin
            if (h_bin == 5'd12)
                commit_value = pm_reg ? 5'd12 : 5'd0;
            else
                commit_value = pm_reg ? h_bin + 5'd12 : h_bin;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            mode_12_reg    <= 1'b0;
            hour_value_reg <= 5'd0;
            load_reg       <= 1'b0;
            hr1_reg        <= 4'd0;
            hr0_reg        <= 4'd0;
            pm_reg         <= 1'b0;
            editing_reg    <= 1'b0;
        end else begin
            load_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg   <= TENS;
                        editing_reg <= 1'b1;
                        mode_12_reg <= mode_12;
                        hr1_reg     <= pre_tens;
                        hr0_reg     <= pre_ones;
                        pm_reg      <= disp_pm;
                    end
                end
                TENS: begin
                    if (abort) begin
                        state_reg   <= IDLE;
                        editing_reg <= 1'b0;
                    end else if (next) begin
                        state_reg <= ONES;
                    end else if (inc) begin
                        hr1_reg <= tens_inc;
                        hr0_reg <= ones_clamped;
                    end
                end
                ONES: begin
                    if (abort) begin
                        state_reg   <= IDLE;
                        editing_reg <= 1'b0;
                    end else if (next) begin
                        if (mode_12_reg) begin
                            state_reg <= AMPM;
                        end else begin
                            state_reg      <= IDLE;
                            editing_reg    <= 1'b0;
                            hour_value_reg <= commit_value;
                            load_reg       <= 1'b1;
                        end
                    end else if (inc) begin
                        hr0_reg <= ones_inc;
                    end
                end
                AMPM: begin
                    if (abort) begin
                        state_reg   <= IDLE;
                        editing_reg <= 1'b0;
                    end else if (next) begin
                        state_reg      <= IDLE;
                        editing_reg    <= 1'b0;
                        hour_value_reg <= commit_value;
                        load_reg       <= 1'b1;
                    end else if (inc) begin
                        pm_reg <= ~pm_reg;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    editing_reg <= 1'b0;
                end
            endcase
        end
    end

    assign hour_value = hour_value_reg;
    assign load       = load_reg;
    assign hr1_edit   = hr1_reg;
    assign hr0_edit   = hr0_reg;
    assign pm_edit    = pm_reg;
    assign editing    = editing_reg;
    assign field      = state_reg;

endmodule

// File: doc/hour_set_ctrl.md
# hour_set_ctrl

Interactive hour-entry controller: the inverse of the clock display's hour conversion. It lets the user edit the hour as BCD digits, in either 12-hour (with AM/PM) or 24-hour format, using one-pulse button inputs. On commit it converts the edited digits back into the binary 24-hour value (0–23) that the time-keeping counters load. It sits between the debounced/one-pulsed push-buttons and the hour counter, and its edit outputs drive the 7-segment display while editing.

## Interface
- No parameters.
- `clk` in 1 — system clock.
- `rst` in 1 — asynchronous, active-high reset.
- `mode_12` in 1 — 1 = 12-hour entry, 0 = 24-hour entry; sampled only on an accepted `start`.
- `start` in 1 — one-cycle pulse; enters edit mode from IDLE.
- `inc` in 1 — one-cycle pulse; increments the active field.
- `next` in 1 — one-cycle pulse; advances to the next field, or commits from the last field.
- `abort` in 1 — one-cycle pulse; leaves edit mode without committing.
- `hour_value` out 5 — committed binary hour, 0–23, registered.
- `load` out 1 — one-cycle pulse; `hour_value` was just updated.
- `hr1_edit` out 4 — edited tens digit, BCD.
- `hr0_edit` out 4 — edited ones digit, BCD.
- `pm_edit` out 1 — edited AM/PM flag, 1 = PM (12-hour only).
- `editing` out 1 — high in any non-IDLE state.
- `field` out 2 — current state encoding: 0 IDLE, 1 TENS, 2 ONES, 3 AMPM.

## Operation
- Reset values:
  - State is IDLE.
  - `hour_value`, `hr1_edit`, `hr0_edit`, `pm_edit`, `load` and `editing` are all 0.
  - Latched mode is 0 (24-hour).
- State transitions:
  - IDLE, `start` → TENS. Latch `mode_12`. Preload the edit registers from `hour_value`:
    - 24-hour: tens and ones of `hour_value`; `pm_edit` = 0.
    - 12-hour: 0 → 1,2,AM; 1–11 → h,AM; 12 → 1,2,PM; 13–23 → h−12,PM. Digits are BCD.
  - TENS, `next` → ONES.
  - ONES, `next` → AMPM in 12-hour mode; in 24-hour mode, commit → IDLE.
  - AMPM, `next` → commit → IDLE.
  - Any edit state, `abort` → IDLE. No commit, `hour_value` unchanged.
- `inc` behaviour per field:
  - TENS, 12-hour: 0→1→0. After the change, clamp ones:
    - tens = 1 and ones > 2 → ones = 2.
    - tens = 0 and ones = 0 → ones = 1.
  - TENS, 24-hour: 0→1→2→0. Clamp: tens = 2 and ones > 3 → ones = 3.
  - ONES, 12-hour: tens = 0 wraps 1..9→1; tens = 1 wraps 0..2→0.
  - ONES, 24-hour: tens < 2 wraps 0..9→0; tens = 2 wraps 0..3→0.
  - AMPM: toggle `pm_edit`.
- Commit conversion (5-bit unsigned arithmetic), with h = 10·tens + ones:
  - 24-hour: result = h.
  - 12-hour, h = 12: AM → 0, PM → 12.
  - 12-hour, other h: PM → h + 12, AM → h.
  - Result is always within 0–23.
- Input priority:
  - `abort` > `next` > `inc`. A lower-priority pulse in the same cycle is ignored.
  - `start` is ignored outside IDLE; `inc`, `next` and `abort` are ignored in IDLE.
- Latched mode is fixed for the whole session; changing `mode_12` mid-edit has no effect.
- Edit registers hold their values in IDLE, so the display keeps the last edit.

## Timing
- All inputs are sampled on the rising `clk` edge; all outputs are registered.
- Any accepted pulse takes effect on the outputs 1 cycle after it is sampled.
- Commit: `hour_value` updates and `load` is high for exactly the one cycle following the edge that sampled the committing `next`. In that same cycle `editing` = 0.
- `load` is never asserted except on commit; back-to-back sessions produce one `load` each.
- Asserting `rst` mid-edit immediately forces IDLE and the reset values listed above. No `load` is produced.

## Test plan
- Reset:
  - Stimulus: assert `rst` asynchronously, mid-cycle.
  - Required: all outputs 0 at once, before the next clock edge; `field` = 0.
- 24-hour entry:
  - Stimulus: from `hour_value` = 0, apply `start`; `inc`×2 (tens = 2); `next`; `inc`×5 (ones 0→1→2→3→0→1); `next`.
  - Required: `hour_value` = 21; `load` high for 1 cycle; `field` = 0.
- 12-hour preload, clamp and midnight:
  - Stimulus: from 21, apply `start`.
  - Required: edit shows 0,9,PM.
  - Stimulus: `inc` on tens.
  - Required: 1,2 (ones clamped 9→2).
  - Stimulus: `next`, `next`, `inc` (PM→AM), `next`.
  - Required: `hour_value` = 0.
- 12-hour PM mapping:
  - Stimulus: commit 12 PM.
  - Required: `hour_value` = 12.
  - Stimulus: commit 07 PM.
  - Required: `hour_value` = 19.
  - Stimulus: commit 11 AM.
  - Required: `hour_value` = 11.
- Priority and abort:
  - Stimulus: `inc` and `next` in the same cycle in TENS.
  - Required: moves to ONES with tens unchanged.
  - Stimulus: `abort` together with the committing `next`.
  - Required: IDLE, no `load`, `hour_value` unchanged.
- Mode latch and reset mid-edit:
  - Stimulus: start in 24-hour mode, toggle `mode_12` mid-edit.
  - Required: ONES `next` still commits directly, with no AMPM state.
  - Stimulus: `rst` while in ONES.
  - Required: IDLE, `hour_value` = 0, no `load`.
